rect_physics_ctl: RTL and testbench
===================================

# rect_physics_ctl

Parametrised successor to the single-rectangle drag/drop controller in the image-control pipeline. The rectangle follows the mouse until the left button is pressed, then falls under fixed-point gravity with damped floor/ceiling bounces and comes to rest. A second press re-grabs it, so drops can be repeated without reset. It sits between the mouse decoder and the rectangle draw stage and drives the rectangle's top-left corner.

## Interface
- VISIBLE_WIDTH, 800: visible area width, pixels.
- VISIBLE_HEIGHT, 600: visible area height, pixels.
- RECT_WIDTH, 48: rectangle width, pixels.
- RECT_HEIGHT, 64: rectangle height, pixels.
- TICK_DIV, 650000: `clk` cycles per physics tick, ≥2.
- VEL_W, 16: signed velocity width, bits.
- FRAC, 4: fractional velocity bits (units of 1/2^FRAC px/tick).
- GRAVITY, 16: velocity added per tick, in fixed-point units.
- DAMP_SHIFT, 1: bounce removes `v>>>DAMP_SHIFT` before reflecting.
- REST_THRESH, 32: post-floor-bounce |vy| below this enters REST.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mouse_left  in  1  left button level.
- mouse_x_position  in  12  mouse x, pixels.
- mouse_y_position  in  12  mouse y, pixels.
- xpos  out  12  rectangle left edge, registered.
- ypos  out  12  rectangle top edge, registered.
- at_rest  out  1  high while in REST, registered.

## Operation
- X_MAX = VISIBLE_WIDTH-RECT_WIDTH; Y_MAX = VISIBLE_HEIGHT-RECT_HEIGHT.
- Press = `mouse_left`=1 with its registered previous value 0. Held level is not a press.
- Tick counter: free-running 0..TICK_DIV-1, including in FOLLOW. `tick` pulses when the count is TICK_DIV-1.
- FOLLOW:
  - xpos = min(mouse_x, X_MAX); ypos = min(mouse_y, Y_MAX). Applied every cycle.
  - On a press: go to FALL with vy=0 and vx per Configuration.
- FALL, on each tick, per axis. Arithmetic is signed 14-bit; `>>>` is arithmetic.
  - Candidate position: c = pos + (v>>>FRAC).
  - Floor/right wall: if c ≥ MAX and v>0, set pos=MAX and v=−(v−(v>>>DAMP_SHIFT)).
  - Ceiling/left wall: if c < 0 and v<0, set pos=0 with the same reflection.
  - Otherwise pos=c.
  - vy: if no y bounce this tick, vy += GRAVITY, saturating at 2^(VEL_W−1)−1.
  - Floor bounce leaving |vy| < REST_THRESH (including vy=0 at Y_MAX): go to REST with vx=vy=0.
- REST: position frozen.
- A press in FALL or REST returns to FOLLOW; velocities are cleared.
- Press and tick in the same cycle: the press wins and no physics update occurs.

## Timing
- Reset: state FOLLOW, xpos=0, ypos=0, at_rest=0, vx=vy=0, tick counter=0, previous-button register=0.
- FOLLOW: xpos/ypos reflect the mouse inputs one cycle after sampling.
- Press sampled at edge N: state changes at edge N+1. The first physics update is at the first tick after that.
- FALL: xpos/ypos change only on the edge following a tick. They are stable otherwise.
- at_rest rises on the same edge as the final ypos=Y_MAX update. It falls on the edge that leaves REST.
- rst mid-FALL: all registers return to reset values on the next edge.

## Configuration
- RECT_THROW_EN defined:
  - Every tick in FOLLOW, store the mouse x delta since the previous tick.
  - At a press, vx = delta<<FRAC, saturated to the VEL_W range.
  - Horizontal motion and side-wall bounces are active in FALL.
- RECT_THROW_EN undefined: vx is constant 0; x is frozen from press until re-grab. Vertical behaviour is identical.

## Test plan
(TICK_DIV=4, defaults otherwise.)
- Clamp: mouse (900,700) in FOLLOW → xpos=752, ypos=536 next cycle.
- Free fall: press at mouse (100,0) → after ticks 1..5, ypos=0,1,3,6,10; xpos stays 100 (throw delta 0).
- Floor bounce: vy=512 at impact → ypos=536, vy=−256; ypos decreases on the following ticks.
- Rest at floor: press at mouse y=536 → the first tick sets ypos=536 and at_rest=1, and ypos never changes afterwards.
- Re-grab: press in REST → at_rest=0; xpos/ypos track the mouse one cycle later; a held button with no new press keeps FOLLOW.
- With RECT_THROW_EN: mouse x moves +10 over the last FOLLOW tick, then press → xpos grows 10/tick; at x≥752 it reflects with vx=−80 (fixed-point, from 160).

Source files
------------

// File: rtl/rect_physics_ctl.sv
// rect_physics_ctl: rectangle follows mouse, drops under fixed-point gravity with damped bounces, re-grabbed by a press.
// Optional horizontal throw when RECT_THROW_EN is defined.
module rect_physics_ctl #(
  parameter int VISIBLE_WIDTH  = 800,
  parameter int VISIBLE_HEIGHT = 600,
  parameter int RECT_WIDTH     = 48,
  parameter int RECT_HEIGHT    = 64,
  parameter int TICK_DIV       = 650000,
  parameter int VEL_W          = 16,
  parameter int FRAC           = 4,
  parameter int GRAVITY        = 16,
  parameter int DAMP_SHIFT     = 1,
  parameter int REST_THRESH    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x_position,
  input  logic [11:0] mouse_y_position,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        at_rest
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [11:0] X_MAX = 12'(VISIBLE_WIDTH - RECT_WIDTH);
  localparam logic [11:0] Y_MAX = 12'(VISIBLE_HEIGHT - RECT_HEIGHT);
  localparam logic signed [13:0] XM = 14'(VISIBLE_WIDTH - RECT_WIDTH);
  localparam logic signed [13:0] YM = 14'(VISIBLE_HEIGHT - RECT_HEIGHT);
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] REST_NEG = VEL_W'(-REST_THRESH);
  typedef enum logic [1:0] {FOLLOW, FALL, REST} state_t;
  function automatic logic signed [13:0] cand(input logic [11:0] p, input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W-1:0] s;
    s = v >>> FRAC;
    return $signed({2'b00, p}) + 14'(s);
  endfunction
  function automatic logic signed [VEL_W-1:0] refl(input logic signed [VEL_W-1:0] v);
    return -(v - (v >>> DAMP_SHIFT));
  endfunction
  state_t state_q, state_d;
  logic btn_q, btn_d, press_q, press_d, at_rest_q, tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic signed [VEL_W-1:0] vy_q, vy_d, vy_ref, vy_grav;
  logic signed [VEL_W:0] vy_sum;
  logic signed [13:0] cy;
  logic y_floor, y_ceil, rest_hit;
`ifdef RECT_THROW_EN
  logic [11:0] last_x_q, last_x_d;
  logic signed [12:0] delta_q, delta_d;
  logic signed [VEL_W-1:0] vx_q, vx_d, vx_throw;
  logic signed [13:0] cx;
  logic x_r, x_l;
  int throw_v;
`endif
  always_comb begin
    btn_d = mouse_left;
    press_d = mouse_left & ~btn_q;
    tick = cnt_q == CW'(TICK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    cy = cand(ypos_q, vy_q);
    // vy=0 resting on the floor counts as a floor hit so it settles instead of accumulating gravity
    y_floor = cy >= YM && vy_q >= 0;
    y_ceil = cy < 0 && vy_q < 0;
    vy_ref = refl(vy_q);
    vy_sum = {vy_q[VEL_W-1], vy_q} + (VEL_W+1)'(GRAVITY);
    vy_grav = vy_sum[VEL_W] != vy_sum[VEL_W-1] ? VMAX : vy_sum[VEL_W-1:0];
    rest_hit = y_floor && vy_ref > REST_NEG;
    state_d = state_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    vy_d = vy_q;
`ifdef RECT_THROW_EN
    cx = cand(xpos_q, vx_q);
    x_r = cx >= XM && vx_q > 0;
    x_l = cx < 0 && vx_q < 0;
    throw_v = int'(delta_q) * (2 ** FRAC);
    vx_throw = throw_v > int'(VMAX) ? VMAX : throw_v < -int'(VMAX) - 1 ? ~VMAX : VEL_W'(throw_v);
    vx_d = vx_q;
    delta_d = (state_q == FOLLOW && tick) ? $signed({1'b0, mouse_x_position}) - $signed({1'b0, last_x_q}) : delta_q;
    last_x_d = (state_q == FOLLOW && tick) ? mouse_x_position : last_x_q;
`endif
    case (state_q)
      FOLLOW: begin
        xpos_d = mouse_x_position > X_MAX ? X_MAX : mouse_x_position;
        ypos_d = mouse_y_position > Y_MAX ? Y_MAX : mouse_y_position;
        if (press_q) begin
          state_d = FALL;
          vy_d = '0;
`ifdef RECT_THROW_EN
          vx_d = vx_throw;
`endif
        end
      end
      FALL: begin
        if (press_q) begin
          state_d = FOLLOW;
          vy_d = '0;
`ifdef RECT_THROW_EN
          vx_d = '0;
`endif
        end else if (tick) begin
          ypos_d = y_floor ? Y_MAX : y_ceil ? '0 : cy[11:0];
          vy_d = (y_floor || y_ceil) ? vy_ref : vy_grav;
`ifdef RECT_THROW_EN
          xpos_d = x_r ? X_MAX : x_l ? '0 : cx[11:0];
          vx_d = (x_r || x_l) ? refl(vx_q) : vx_q;
`endif
          if (rest_hit) begin
            state_d = REST;
            vy_d = '0;
`ifdef RECT_THROW_EN
            vx_d = '0;
`endif
          end
        end
      end
      REST: state_d = press_q ? FOLLOW : REST;
      default: state_d = FOLLOW;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FOLLOW;
      btn_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
      xpos_q <= '0;
      ypos_q <= '0;
      vy_q <= '0;
      at_rest_q <= 1'b0;
`ifdef RECT_THROW_EN
      last_x_q <= '0;
      delta_q <= '0;
      vx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      btn_q <= btn_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      vy_q <= vy_d;
      at_rest_q <= state_d == REST;
`ifdef RECT_THROW_EN
      last_x_q <= last_x_d;
      delta_q <= delta_d;
      vx_q <= vx_d;
`endif
    end
  end
  assign xpos = xpos_q;
  assign ypos = ypos_q;
  assign at_rest = at_rest_q;
endmodule

// File: tb/tb_rect_physics_ctl.sv
// tb_rect_physics_ctl: scoreboard bench for rect_physics_ctl with TICK_DIV=4 and directed hand-computed vectors.
module tb_rect_physics_ctl;
  logic clk = 1'b0, rst = 1'b1, mouse_left = 1'b0;
  logic [11:0] mx = '0, my = '0;
  logic [11:0] xpos, ypos;
  logic at_rest;
  typedef struct {
    int cyc;
    string name;
    logic [11:0] x;
    logic [11:0] y;
    logic r;
    logic cy;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, mcnt = 0, passed = 0, total = 0;
  rect_physics_ctl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left),
    .mouse_x_position(mx), .mouse_y_position(my),
    .xpos(xpos), .ypos(ypos), .at_rest(at_rest)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // independent tick model: counter 0..3, the update lands on the edge where it reads 3
  always @(posedge clk) mcnt <= rst ? 0 : (mcnt == 3 ? 0 : mcnt + 1);
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (xpos !== e.x || (e.cy && ypos !== e.y) || at_rest !== e.r)
        $display("FAIL %s: got x=%0d y=%0d rest=%0b, want x=%0d y=%0d rest=%0b",
                 e.name, xpos, ypos, at_rest, e.x, e.cy ? e.y : ypos, e.r);
      else passed++;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic after_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (mcnt != 3 && n < 16);
    if (mcnt != 3) begin
      total++;
      $display("FAIL tick_wait: got no tick in %0d cycles, want one within 4", n);
    end
    #1;
  endtask
  task automatic chk(input string n, input int x, input int y, input bit r, input bit use_y);
    sb.push_back('{cyc, n, 12'(x), 12'(y), r, use_y});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want earlier");
    $fatal(1);
  end
  initial begin
    int fy[5] = '{0, 1, 3, 6, 10};
    int tx[7];
`ifdef RECT_THROW_EN
    tx = '{710, 720, 730, 740, 750, 752, 747};
`else
    tx = '{700, 700, 700, 700, 700, 700, 700};
`endif
    step(2);
    chk("reset", 0, 0, 0, 1);
    rst = 1'b0;
    mx = 900; my = 700; step(1); chk("clamp_over", 752, 536, 0, 1);
    mx = 753; my = 537; step(1); chk("clamp_edge1", 752, 536, 0, 1);
    mx = 752; my = 536; step(1); chk("clamp_exact", 752, 536, 0, 1);
    mx = 300; my = 200; step(1); chk("follow", 300, 200, 0, 1);
    mx = 100; my = 0; after_tick(); after_tick(); chk("follow_pre", 100, 0, 0, 1);
    mouse_left = 1'b1; step(2);
    for (int k = 0; k < 5; k++) begin
      after_tick();
      chk($sformatf("fall_t%0d", k + 1), 100, fy[k], 0, 1);
    end
    step(2); chk("fall_stable", 100, 10, 0, 1);
    for (int k = 6; k <= 33; k++) after_tick();
    after_tick(); chk("floor_bounce", 100, 536, 0, 1);
    after_tick(); chk("rebound1", 100, 519, 0, 1);
    after_tick(); chk("rebound2", 100, 503, 0, 1);
    mouse_left = 1'b0; step(1);
    mx = 200; my = 536; mouse_left = 1'b1; step(3);
    chk("regrab_fall", 200, 536, 0, 1);
    after_tick(); after_tick();
    mouse_left = 1'b0; step(1);
    mouse_left = 1'b1; step(2);
    after_tick(); chk("rest_hit", 200, 536, 1, 1);
    for (int k = 0; k < 3; k++) after_tick();
    chk("rest_hold", 200, 536, 1, 1);
    mouse_left = 1'b0; step(1);
    mx = 400; my = 100; mouse_left = 1'b1; step(2);
    chk("leave_rest", 200, 536, 0, 1);
    step(1); chk("regrab_track", 400, 100, 0, 1);
    mx = 410; my = 120; after_tick(); after_tick();
    chk("held_follow", 410, 120, 0, 1);
    mouse_left = 1'b0; mx = 690; my = 0;
    after_tick(); after_tick();
    mx = 700; after_tick(); chk("throw_pre", 700, 0, 0, 1);
    mouse_left = 1'b1; step(2);
    for (int k = 0; k < 7; k++) begin
      after_tick();
      chk($sformatf("throw_t%0d", k + 1), tx[k], 0, 0, 0);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
